// File: rtl/fx_pkg.sv
// Shared definitions for the fx register bus arbiter: bus widths, FSM states
// and master identifiers.
package fx_pkg;

  localparam int FX_AW = 22;
  localparam int FX_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_ACK     = 2'd3
  } fx_state_e;

  localparam logic M_UART = 1'b0;
  localparam logic M_HOST = 1'b1;

endpackage

// File: rtl/fx_arb2_rr.sv
// Two-request round-robin picker. On a tie the master that did not win last
// time is chosen; the pointer only moves when a grant is actually issued.
module rr_arb2
  import fx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q, last_d;
  logic pick;

  always_comb begin
    gnt  = 2'b00;
    pick = M_UART;
    if (en && (req != 2'b00)) begin
      if (req == 2'b11) pick = ~last_q;
      else              pick = req[1];
      gnt = pick ? 2'b10 : 2'b01;
    end
    last_d = (gnt != 2'b00) ? pick : last_q;
  end

  // Pointer starts at the host so the UART path wins the first tie
  always_ff @(posedge clk) begin
    if (rst) last_q <= M_HOST;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/fx_arb2.sv
// Two-master arbiter/sequencer for the fx register bus: serialises single-byte
// reads and writes, waits a fixed read latency and returns data with an ack.
module fx_arb2
  import fx_pkg::*;
#(
  parameter int AW     = FX_AW,
  parameter int DW     = FX_DW,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q,
  output logic          busy,
  output logic          gnt_id
);

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  fx_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          cmd_we_q, cmd_we_d;
  logic          gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;
  logic          fx_wr_q, fx_wr_d, fx_rd_q, fx_rd_d;
  logic [AW-1:0] fx_waddr_q, fx_waddr_d, fx_raddr_q, fx_raddr_d;
  logic [DW-1:0] fx_data_q, fx_data_d;
  logic          m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic [1:0]    gnt;
  logic          arb_en;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign arb_en = (state_q == ST_IDLE);

  rr_arb2 u_rr (
    .clk (clk_sys),
    .rst (rst),
    .req ({m1_req, m0_req}),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    sel_we     = gnt[1] ? m1_we    : m0_we;
    sel_addr   = gnt[1] ? m1_addr  : m0_addr;
    sel_wdata  = gnt[1] ? m1_wdata : m0_wdata;

    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_we_d   = cmd_we_q;
    gnt_id_d   = gnt_id_q;
    fx_wr_d    = 1'b0;
    fx_rd_d    = 1'b0;
    fx_waddr_d = fx_waddr_q;
    fx_raddr_d = fx_raddr_q;
    fx_data_d  = fx_data_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    // Strobes and bus fields are loaded at grant so they appear in the ISSUE cycle
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          gnt_id_d = gnt[1];
          cmd_we_d = sel_we;
          state_d  = ST_ISSUE;
          if (sel_we) begin
            fx_wr_d    = 1'b1;
            fx_waddr_d = sel_addr;
            fx_data_d  = sel_wdata;
          end else begin
            fx_rd_d    = 1'b1;
            fx_raddr_d = sel_addr;
          end
        end
      end
      ST_ISSUE: begin
        if (cmd_we_q) begin
          m0_ack_d = (gnt_id_q == M_UART);
          m1_ack_d = (gnt_id_q == M_HOST);
          state_d  = ST_ACK;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (cnt_q == 4'd0) begin
          if (gnt_id_q == M_HOST) m1_rdata_d = fx_q;
          else                    m0_rdata_d = fx_q;
          m0_ack_d = (gnt_id_q == M_UART);
          m1_ack_d = (gnt_id_q == M_HOST);
          state_d  = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      cmd_we_q   <= 1'b0;
      gnt_id_q   <= M_UART;
      busy_q     <= 1'b0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      fx_waddr_q <= '0;
      fx_raddr_q <= '0;
      fx_data_q  <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_we_q   <= cmd_we_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      fx_wr_q    <= fx_wr_d;
      fx_rd_q    <= fx_rd_d;
      fx_waddr_q <= fx_waddr_d;
      fx_raddr_q <= fx_raddr_d;
      fx_data_q  <= fx_data_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign fx_wr    = fx_wr_q;
  assign fx_rd    = fx_rd_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_raddr = fx_raddr_q;
  assign fx_data  = fx_data_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_id_q;

endmodule

// File: tb/tb_fx_arb2.sv
// Bench for fx_arb2: a default RD_LAT=2 instance plus an RD_LAT=1 instance,
// with expected acks queued at stimulus time and checked as they arrive.
module tb_fx_arb2;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [21:0] m0_addr, m1_addr, fx_waddr, fx_raddr;
  logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, fx_data, fx_q;
  logic        m0_ack, m1_ack, fx_wr, fx_rd, busy, gnt_id;

  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [21:0] b_m0_addr, b_m1_addr, b_fx_waddr, b_fx_raddr;
  logic [7:0]  b_m0_wdata, b_m1_wdata, b_m0_rdata, b_m1_rdata, b_fx_data, b_fx_q;
  logic        b_m0_ack, b_m1_ack, b_fx_wr, b_fx_rd, b_busy, b_gnt_id;

  fx_arb2 #(.AW(22), .DW(8), .RD_LAT(2)) u_dut (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .busy(busy), .gnt_id(gnt_id)
  );

  fx_arb2 #(.AW(22), .DW(8), .RD_LAT(1)) u_dut1 (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .fx_wr(b_fx_wr), .fx_waddr(b_fx_waddr), .fx_data(b_fx_data),
    .fx_rd(b_fx_rd), .fx_raddr(b_fx_raddr), .fx_q(b_fx_q),
    .busy(b_busy), .gnt_id(b_gnt_id)
  );

  typedef struct {
    logic       id;
    logic       rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push_exp(input logic id, input logic rd, input logic [7:0] data, input int cyc);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_sys);
    n_vec++;
    if ({fx_wr, fx_rd, busy, gnt_id, m0_ack, m1_ack} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl got %b exp 000000", {fx_wr, fx_rd, busy, gnt_id, m0_ack, m1_ack});
    end
    n_vec++;
    if ({fx_waddr, fx_raddr, fx_data} !== 52'h0) begin
      n_err++; $display("FAIL reset_bus got %h exp 0", {fx_waddr, fx_raddr, fx_data});
    end
    n_vec++;
    if ({m0_rdata, m1_rdata} !== 16'h0) begin
      n_err++; $display("FAIL reset_rdata got %h exp 0000", {m0_rdata, m1_rdata});
    end
    n_vec++;
    if ({b_fx_wr, b_fx_rd, b_busy, b_gnt_id, b_m0_ack, b_m1_ack} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl_lat1 got %b exp 000000", {b_fx_wr, b_fx_rd, b_busy, b_gnt_id, b_m0_ack, b_m1_ack});
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    exp_t e;
    m0_we = 1'b1; m0_addr = 22'h040012; m0_wdata = 8'hA5; m0_req = 1'b1;
    push_exp(1'b0, 1'b0, 8'h00, 2);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_sys); #1;
      if (k == 2) m0_req = 1'b0;
      @(negedge clk_sys);
      n_vec++;
      if ({fx_wr, fx_rd} !== {1'(k == 1), 1'b0}) begin
        n_err++; $display("FAIL write_strobe cyc %0d got wr/rd %b%b exp %b0", k, fx_wr, fx_rd, 1'(k == 1));
      end
      n_vec++;
      if (busy !== 1'(k <= 2)) begin
        n_err++; $display("FAIL write_busy cyc %0d got %b exp %b", k, busy, 1'(k <= 2));
      end
      if (k == 1) begin
        n_vec++;
        if ({fx_waddr, fx_data, gnt_id} !== {22'h040012, 8'hA5, 1'b0}) begin
          n_err++; $display("FAIL write_bus got addr %h data %h gnt %b exp 040012 a5 0", fx_waddr, fx_data, gnt_id);
        end
      end
      if (m0_ack | m1_ack) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL write_ack unexpected ack at cyc %0d", k);
        end else begin
          e = sb.pop_front();
          if ({m1_ack, m0_ack, k} !== {e.id, ~e.id, e.cyc}) begin
            n_err++; $display("FAIL write_ack got m1/m0 %b%b cyc %0d exp id %0d cyc %0d", m1_ack, m0_ack, k, e.id, e.cyc);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL write_missing_ack got %0d pending exp 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_read();
    exp_t e;
    logic [7:0] m0_prev;
    logic [7:0] got;
    m0_prev = m0_rdata;
    m1_we = 1'b0; m1_addr = 22'h100003; m1_req = 1'b1;
    push_exp(1'b1, 1'b1, 8'h3C, 4);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_sys); #1;
      fx_q = (k == 3) ? 8'h3C : 8'hEE;
      if (k == 4) m1_req = 1'b0;
      @(negedge clk_sys);
      n_vec++;
      if ({fx_rd, fx_wr} !== {1'(k == 1), 1'b0}) begin
        n_err++; $display("FAIL read_strobe cyc %0d got rd/wr %b%b exp %b0", k, fx_rd, fx_wr, 1'(k == 1));
      end
      if (k == 1) begin
        n_vec++;
        if ({fx_raddr, fx_waddr, gnt_id} !== {22'h100003, 22'h040012, 1'b1}) begin
          n_err++; $display("FAIL read_bus got raddr %h waddr %h gnt %b exp 100003 040012 1", fx_raddr, fx_waddr, gnt_id);
        end
      end
      if (m0_ack | m1_ack) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL read_ack unexpected ack at cyc %0d", k);
        end else begin
          e = sb.pop_front();
          got = e.id ? m1_rdata : m0_rdata;
          if ({m1_ack, m0_ack, k, got} !== {e.id, ~e.id, e.cyc, e.data}) begin
            n_err++; $display("FAIL read_ack got m1/m0 %b%b cyc %0d data %h exp id %0d cyc %0d data %h", m1_ack, m0_ack, k, got, e.id, e.cyc, e.data);
          end
        end
      end
      n_vec++;
      if (m0_rdata !== m0_prev) begin
        n_err++; $display("FAIL read_other_rdata cyc %0d got %h exp %h", k, m0_rdata, m0_prev);
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL read_missing_ack got %0d pending exp 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_fairness();
    exp_t e;
    int   n0, n1, idx;
    n0 = 0; n1 = 0;
    m0_we = 1'b1; m0_addr = 22'h0A0A0A; m0_wdata = 8'h11;
    m1_we = 1'b1; m1_addr = 22'h3FFFFF; m1_wdata = 8'h22;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 6; i++) push_exp(1'(i % 2), 1'b0, 8'h00, 2 + 3 * i);
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk_sys); #1;
      if (k == 17) begin m0_req = 1'b0; m1_req = 1'b0; end
      @(negedge clk_sys);
      n_vec++;
      if ({fx_wr, fx_rd} !== {1'((k % 3 == 1) && (k <= 16)), 1'b0}) begin
        n_err++; $display("FAIL fair_strobe cyc %0d got wr/rd %b%b exp %b0", k, fx_wr, fx_rd, 1'((k % 3 == 1) && (k <= 16)));
      end
      if (fx_wr) begin
        idx = ((k - 1) / 3) % 2;
        n_vec++;
        if ({fx_waddr, fx_data, gnt_id} !== ((idx == 1) ? {22'h3FFFFF, 8'h22, 1'b1} : {22'h0A0A0A, 8'h11, 1'b0})) begin
          n_err++; $display("FAIL fair_grant cyc %0d got addr %h data %h gnt %b exp master %0d", k, fx_waddr, fx_data, gnt_id, idx);
        end
      end
      if (m0_ack | m1_ack) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL fair_ack unexpected ack at cyc %0d", k);
        end else begin
          e = sb.pop_front();
          if ({m1_ack, m0_ack, k} !== {e.id, ~e.id, e.cyc}) begin
            n_err++; $display("FAIL fair_ack got m1/m0 %b%b cyc %0d exp id %0d cyc %0d", m1_ack, m0_ack, k, e.id, e.cyc);
          end
        end
        if (m0_ack) n0++;
        if (m1_ack) n1++;
      end
    end
    n_vec++;
    if ({n0, n1, sb.size()} !== {32'd3, 32'd3, 32'd0}) begin
      n_err++; $display("FAIL fair_count got m0 %0d m1 %0d pending %0d exp 3 3 0", n0, n1, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_contention();
    exp_t e;
    logic [7:0] got;
    m0_we = 1'b0; m0_addr = 22'h2AAAAA; m0_req = 1'b1;
    push_exp(1'b0, 1'b1, 8'h77, 4);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_sys); #1;
      fx_q = (k == 3) ? 8'h77 : 8'h00;
      if (k == 1) begin
        m1_we = 1'b1; m1_addr = 22'h155555; m1_wdata = 8'h5A; m1_req = 1'b1;
        push_exp(1'b1, 1'b0, 8'h00, 7);
      end
      if (k == 4) m0_req = 1'b0;
      if (k == 7) m1_req = 1'b0;
      @(negedge clk_sys);
      n_vec++;
      if ({fx_rd, fx_wr, busy} !== {1'(k == 1), 1'(k == 6), 1'(k != 5 && k != 8)}) begin
        n_err++; $display("FAIL cont_ctrl cyc %0d got rd/wr/busy %b%b%b exp %b%b%b", k, fx_rd, fx_wr, busy, 1'(k == 1), 1'(k == 6), 1'(k != 5 && k != 8));
      end
      n_vec++;
      if (gnt_id !== 1'(k >= 6)) begin
        n_err++; $display("FAIL cont_gnt_id cyc %0d got %b exp %b", k, gnt_id, 1'(k >= 6));
      end
      if (k == 6) begin
        n_vec++;
        if ({fx_waddr, fx_data, fx_raddr} !== {22'h155555, 8'h5A, 22'h2AAAAA}) begin
          n_err++; $display("FAIL cont_bus got waddr %h data %h raddr %h exp 155555 5a 2aaaaa", fx_waddr, fx_data, fx_raddr);
        end
      end
      if (m0_ack | m1_ack) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL cont_ack unexpected ack at cyc %0d", k);
        end else begin
          e = sb.pop_front();
          got = e.id ? m1_rdata : m0_rdata;
          if ({m1_ack, m0_ack, k} !== {e.id, ~e.id, e.cyc} || (e.rd && got !== e.data)) begin
            n_err++; $display("FAIL cont_ack got m1/m0 %b%b cyc %0d data %h exp id %0d cyc %0d data %h", m1_ack, m0_ack, k, got, e.id, e.cyc, e.data);
          end
        end
      end
    end
    n_vec++;
    if ({m1_rdata, 32'(sb.size())} !== {8'h3C, 32'd0}) begin
      n_err++; $display("FAIL cont_end got m1_rdata %h pending %0d exp 3c 0", m1_rdata, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    m0_we = 1'b0; m0_addr = 22'h123456; m0_req = 1'b1;
    fx_q = 8'hEE;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_sys); #1;
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        rst = 1'b0;
        m0_we = 1'b1; m0_addr = 22'h000AAA; m0_wdata = 8'hC3;
        m1_we = 1'b1; m1_addr = 22'h000BBB; m1_wdata = 8'h3D;
        m0_req = 1'b1; m1_req = 1'b1;
        push_exp(1'b0, 1'b0, 8'h00, 5);
        push_exp(1'b1, 1'b0, 8'h00, 8);
      end
      if (k == 5) m0_req = 1'b0;
      if (k == 8) m1_req = 1'b0;
      @(negedge clk_sys);
      if (k == 3) begin
        n_vec++;
        if ({fx_wr, fx_rd, busy, gnt_id, m0_ack, m1_ack} !== 6'b0) begin
          n_err++; $display("FAIL abort_ctrl got %b exp 000000", {fx_wr, fx_rd, busy, gnt_id, m0_ack, m1_ack});
        end
        n_vec++;
        if ({m0_rdata, m1_rdata, fx_waddr, fx_raddr, fx_data} !== 68'h0) begin
          n_err++; $display("FAIL abort_data got %h exp 0", {m0_rdata, m1_rdata, fx_waddr, fx_raddr, fx_data});
        end
      end
      n_vec++;
      if ({fx_rd, fx_wr} !== {1'(k == 1), 1'(k == 4 || k == 7)}) begin
        n_err++; $display("FAIL abort_strobe cyc %0d got rd/wr %b%b exp %b%b", k, fx_rd, fx_wr, 1'(k == 1), 1'(k == 4 || k == 7));
      end
      if (k == 4 || k == 7) begin
        n_vec++;
        if ({fx_waddr, fx_data, gnt_id} !== ((k == 4) ? {22'h000AAA, 8'hC3, 1'b0} : {22'h000BBB, 8'h3D, 1'b1})) begin
          n_err++; $display("FAIL abort_grant cyc %0d got addr %h data %h gnt %b", k, fx_waddr, fx_data, gnt_id);
        end
      end
      if (m0_ack | m1_ack) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL abort_ack unexpected ack at cyc %0d", k);
        end else begin
          e = sb.pop_front();
          if ({m1_ack, m0_ack, k} !== {e.id, ~e.id, e.cyc}) begin
            n_err++; $display("FAIL abort_ack got m1/m0 %b%b cyc %0d exp id %0d cyc %0d", m1_ack, m0_ack, k, e.id, e.cyc);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL abort_missing_ack got %0d pending exp 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_rdlat1();
    exp_t e;
    b_m0_we = 1'b0; b_m0_addr = 22'h000001; b_m0_req = 1'b1;
    push_exp(1'b0, 1'b1, 8'h9D, 3);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_sys); #1;
      b_fx_q = (k == 2) ? 8'h9D : 8'h00;
      if (k == 3) b_m0_req = 1'b0;
      @(negedge clk_sys);
      n_vec++;
      if ({b_fx_rd, b_fx_wr} !== {1'(k == 1), 1'b0}) begin
        n_err++; $display("FAIL lat1_strobe cyc %0d got rd/wr %b%b exp %b0", k, b_fx_rd, b_fx_wr, 1'(k == 1));
      end
      if (k == 1) begin
        n_vec++;
        if (b_fx_raddr !== 22'h000001) begin
          n_err++; $display("FAIL lat1_raddr got %h exp 000001", b_fx_raddr);
        end
      end
      n_vec++;
      if ({b_m1_ack, b_m1_rdata, b_fx_waddr, b_fx_data, b_gnt_id, b_busy} !== {39'h0, 1'(k <= 3)}) begin
        n_err++; $display("FAIL lat1_idle cyc %0d got %h busy %b exp busy %b", k, {b_m1_ack, b_m1_rdata, b_fx_waddr, b_fx_data, b_gnt_id}, b_busy, 1'(k <= 3));
      end
      if (b_m0_ack) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL lat1_ack unexpected ack at cyc %0d", k);
        end else begin
          e = sb.pop_front();
          if ({k, b_m0_rdata} !== {e.cyc, e.data}) begin
            n_err++; $display("FAIL lat1_ack got cyc %0d data %h exp cyc %0d data %h", k, b_m0_rdata, e.cyc, e.data);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL lat1_missing_ack got %0d pending exp 0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    fx_q = 8'hEE;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
    b_fx_q = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_contention();
    test_reset_abort();
    test_rdlat1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
